// File: rtl/osc_pkg.sv
// osc_pkg: shared waveform codes and tuning helper for the NCO oscillator
//   WAVE_SAW_UP/WAVE_SAW_DN/WAVE_SQUARE/WAVE_TRI : wave_sel encodings
//   tune_for_hz(hz, f_clk, div, acc_w)           : tuning word for a target frequency
package osc_pkg;
    localparam logic [1:0] WAVE_SAW_UP = 2'b00;
    localparam logic [1:0] WAVE_SAW_DN = 2'b01;
    localparam logic [1:0] WAVE_SQUARE = 2'b10;
    localparam logic [1:0] WAVE_TRI    = 2'b11;

    // tune = hz * div * 2^acc_w / f_clk, truncated
    function automatic longint unsigned tune_for_hz(input longint unsigned hz,
                                                    input longint unsigned f_clk,
                                                    input longint unsigned div,
                                                    input int acc_w);
        return ((hz * div) << acc_w) / f_clk;
    endfunction
endpackage

// File: rtl/osc_wave_shaper.sv
// osc_wave_shaper: combinational phase -> sample mapping
//   phase       in  OUT_W  top bits of the next accumulator value
//   wave_sel    in  2      00 saw up, 01 saw down, 10 square, 11 triangle
//   pulse_width in  OUT_W  square is high while phase < pulse_width
//   sample      out OUT_W  shaped unsigned sample
//   Macro OSC_TRIANGLE_EN enables the triangle; otherwise 11 acts as saw up.
module osc_wave_shaper
    import osc_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic [OUT_W-1:0] phase,
    input  logic [1:0]       wave_sel,
    input  logic [OUT_W-1:0] pulse_width,
    output logic [OUT_W-1:0] sample
);
    logic [OUT_W-1:0] sq;
    assign sq = (phase < pulse_width) ? '1 : '0;
`ifdef OSC_TRIANGLE_EN
    logic [OUT_W-1:0] t, tri_w;
    // doubled phase rises over the first half, mirrored over the second
    assign t     = {phase[OUT_W-2:0], 1'b0};
    assign tri_w = phase[OUT_W-1] ? ~t : t;
    always_comb
        sample = (wave_sel == WAVE_SAW_DN) ? ~phase :
                 (wave_sel == WAVE_SQUARE) ? sq :
                 (wave_sel == WAVE_TRI)    ? tri_w : phase;
`else
    always_comb
        sample = (wave_sel == WAVE_SAW_DN) ? ~phase :
                 (wave_sel == WAVE_SQUARE) ? sq : phase;
`endif
endmodule

// File: rtl/wave_osc_nco.sv
// wave_osc_nco: phase-accumulator oscillator with selectable waveform and sample strobe
//   clk12MHz     in  1      system clock
//   rst          in  1      asynchronous reset, active-high
//   enable       in  1      1 = run, 0 = freeze
//   tune_word    in  ACC_W  phase increment per sample
//   tune_load    in  1      strobe capturing tune_word
//   wave_sel     in  2      waveform select
//   pulse_width  in  OUT_W  square threshold
//   sync_in      in  1      hard sync, phase to 0
//   sample_out   out OUT_W  current sample
//   sample_valid out 1      pulse when sample_out updates
//   wrap         out 1      pulse on accumulator carry-out
//   Macro OSC_TRIANGLE_EN (in osc_wave_shaper) enables the triangle waveform.
module wave_osc_nco
    import osc_pkg::*;
#(
    parameter int OUT_W = 12,
    parameter int ACC_W = 24,
    parameter int DIV   = 256
) (
    input  logic             clk12MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic [ACC_W-1:0] tune_word,
    input  logic             tune_load,
    input  logic [1:0]       wave_sel,
    input  logic [OUT_W-1:0] pulse_width,
    input  logic             sync_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             wrap
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]    presc;
    logic [ACC_W-1:0] acc, tune_pend, tune_act, acc_next;
    logic [ACC_W:0]   sum;
    logic [OUT_W-1:0] shaped;
    logic             tick;

    assign tick     = enable && (presc == PW'(DIV - 1));
    assign sum      = {1'b0, acc} + {1'b0, tune_act};
    // sync overrides the accumulation, so a synced sample never reports a wrap
    assign acc_next = sync_in ? '0 : sum[ACC_W-1:0];

    osc_wave_shaper #(.OUT_W(OUT_W)) u_shaper (
        .phase       (acc_next[ACC_W-1 -: OUT_W]),
        .wave_sel    (wave_sel),
        .pulse_width (pulse_width),
        .sample      (shaped)
    );

    always_ff @(posedge clk12MHz or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            acc          <= '0;
            tune_pend    <= '0;
            tune_act     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            if (tune_load)
                tune_pend <= tune_word;
            if (!enable) begin
                presc        <= '0;
                sample_valid <= 1'b0;
                wrap         <= 1'b0;
            end else begin
                presc        <= tick ? '0 : presc + PW'(1);
                sample_valid <= tick;
                wrap         <= tick && !sync_in && sum[ACC_W];
                if (tick) begin
                    // this tick still accumulates with the old tune_act
                    tune_act   <= tune_pend;
                    acc        <= acc_next;
                    sample_out <= shaped;
                end else if (sync_in)
                    acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wave_osc_nco.sv
// tb_wave_osc_nco: randomized scoreboard bench for wave_osc_nco (OUT_W=12, ACC_W=24, DIV=4)
module tb_wave_osc_nco;
    import osc_pkg::*;
    localparam int DIV = 4;
    localparam longint unsigned MOD = 64'd1 << 24;

    logic        clk12MHz = 1'b0;
    logic        rst = 1'b1, enable = 1'b0, tune_load = 1'b0, sync_in = 1'b0;
    logic [23:0] tune_word = '0;
    logic [1:0]  wave_sel = 2'b00;
    logic [11:0] pulse_width = '0;
    logic [11:0] sample_out;
    logic        sample_valid, wrap;

    typedef struct { logic [11:0] s; logic w; } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0, n_valid = 0;
    longint unsigned m_acc = 0, m_pend = 0, m_act = 0;
    int m_cnt = 0;

    wave_osc_nco #(.OUT_W(12), .ACC_W(24), .DIV(DIV)) dut (
        .clk12MHz     (clk12MHz),
        .rst          (rst),
        .enable       (enable),
        .tune_word    (tune_word),
        .tune_load    (tune_load),
        .wave_sel     (wave_sel),
        .pulse_width  (pulse_width),
        .sync_in      (sync_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    always #5 clk12MHz = ~clk12MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // waveform shapes computed arithmetically from the phase value
    function automatic logic [11:0] shape(input longint unsigned acc, input logic [1:0] ws,
                                          input logic [11:0] pw);
        int p;
        p = int'((acc >> 12) % 4096);
        if (ws == 2'b01) return 12'(4095 - p);
        if (ws == 2'b10) return (p < int'(pw)) ? 12'hFFF : 12'h000;
`ifdef OSC_TRIANGLE_EN
        if (ws == 2'b11) return (p < 2048) ? 12'(2 * p) : 12'(4095 - (2 * p - 4096));
`endif
        return 12'(p);
    endfunction

    always @(negedge clk12MHz) begin
        if (sample_valid === 1'b1) begin
            n_valid++;
            if (q.size() == 0)
                check("unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("sample", 32'(sample_out), 32'(e.s));
                check("wrap", 32'(wrap), 32'(e.w));
            end
        end
    end

    // drive one clock worth of inputs; the model predicts the edge they will see
    task automatic cyc(input bit en, input bit sy, input bit ld = 1'b0, input logic [23:0] tw = '0);
        bit tick;
        longint unsigned s;
        exp_t e;
        enable = en; sync_in = sy; tune_load = ld; tune_word = tw;
        tick = 1'b0;
        if (en) begin
            if (m_cnt == DIV - 1) begin tick = 1'b1; m_cnt = 0; end
            else m_cnt++;
        end else m_cnt = 0;
        if (tick) begin
            s = sy ? 0 : m_acc + m_act;
            e.w = (s >= MOD);
            m_acc = s % MOD;
            e.s = shape(m_acc, wave_sel, pulse_width);
            q.push_back(e);
            m_act = m_pend;
        end else if (en && sy)
            m_acc = 0;
        if (ld) m_pend = longint'(tw);
        @(negedge clk12MHz);
    endtask

    task automatic run_ticks(input int n);
        repeat (n * DIV) cyc(1'b1, 1'b0);
    endtask

    initial begin
        logic [11:0] held;
        int v0, guard;
        repeat (2) @(negedge clk12MHz);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("tune_for_hz", 32'(tune_for_hz(440, 12_000_000, 256, 24)), 32'd157482);
        rst = 1'b0;

        // saw up ramp through one full accumulator wrap
        cyc(1'b1, 1'b0, 1'b1, 24'h001000);
        run_ticks(4100);

        // square at 50% and at zero width
        wave_sel = 2'b10; pulse_width = 12'h800;
        cyc(1'b1, 1'b0, 1'b1, 24'h100000);
        run_ticks(40);
        pulse_width = 12'h000;
        run_ticks(20);
        pulse_width = 12'hFFF;
        run_ticks(20);

        // triangle (saw up when the feature is compiled out)
        wave_sel = 2'b11;
        run_ticks(20);

        // sync away from a tick, then sync landing on the tick at phase 0x5A0
        wave_sel = 2'b00;
        cyc(1'b1, 1'b0, 1'b1, 24'h0B4000);
        run_ticks(3);
        while (m_cnt != 0) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        guard = 0;
        while (!(m_cnt == DIV - 1 && ((m_acc + m_act) >> 12) % 4096 == 64'h5A0) && guard < 400) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        check("sync_reach_5a0", 32'(guard < 400), 32'd1);
        cyc(1'b1, 1'b1);
        run_ticks(3);

        // freeze for 20 clocks mid-ramp, sync ignored while frozen
        run_ticks(2);
        cyc(1'b1, 1'b0);
        held = sample_out;
        v0 = n_valid;
        repeat (10) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (9) cyc(1'b0, 1'b0);
        #1;
        check("hold_sample", 32'(sample_out), 32'(held));
        check("hold_no_valid", 32'(n_valid), 32'(v0));
        repeat (DIV - 1) cyc(1'b1, 1'b0);
        #1;
        check("resume_early", 32'(n_valid), 32'(v0));
        cyc(1'b1, 1'b0);
        #1;
        check("resume_on_time", 32'(n_valid), 32'(v0 + 1));

        // async reset between ticks
        while (m_cnt != 1) cyc(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_sample", 32'(sample_out), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        @(negedge clk12MHz);
        rst = 1'b0;
        m_acc = 0; m_cnt = 0; m_pend = 0; m_act = 0;
        check("arst_queue", 32'(q.size()), 32'd0);
        q.delete();
        run_ticks(5);
        cyc(1'b1, 1'b0, 1'b1, 24'h0C0000);
        run_ticks(5);

        // randomized mix of everything
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0) begin
                wave_sel = 2'($urandom_range(0, 3));
                pulse_width = 12'($urandom);
            end
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 30) == 0,
                $urandom_range(0, 15) == 0, 24'($urandom));
        end

        repeat (2 * DIV) cyc(1'b0, 1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
